// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys memory-loader block: controller state
// encoding and the word-packing constant.
package minisys_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_RX   = 2'd2,
    FINISH    = 2'd3
  } load_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/btn_debounce.sv
// Mode-button conditioner: 2-FF synchronizer, stable-high counter and a
// single-cycle press pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;

  // The debounced level is implicit: sync2_q high with cnt_q saturated at
  // DEB_CYCLES. The press pulse fires on the single cycle the count saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync2_q takes the pre-edge sync1_q value,
      // giving two real flops instead of one.
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (!sync2_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(DEB_CYCLES)) begin
        cnt_q <= cnt_q + 1'b1;
        press <= (cnt_q == CNT_W'(DEB_CYCLES - 1));
      end
    end
  end

endmodule

// File: rtl/minisys_load_ctrl.sv
// RUN/LOAD mode controller: hands the memory write ports to the CPU or to the
// UART loader, packing received bytes little-endian into sequential words.
module minisys_load_ctrl
  import minisys_pkg::*;
#(
  parameter int DEB_CYCLES = 100000,
  parameter int ADDR_W     = 14,
  parameter int TIMEOUT    = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              cpu_dmem_we,
  input  logic [ADDR_W-1:0] cpu_dmem_addr,
  input  logic [31:0]       cpu_dmem_wdata,
  output logic              cpu_rst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              load_active,
  output logic              load_error
);

  // Word counter spans imem then dmem; its top bit set means both are full.
  localparam int WC_W   = ADDR_W + 2;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (btn_mode),
    .press (press)
  );

  load_state_e       state_q, state_d;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       asm_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              ld_imem_we_q, ld_dmem_we_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ld_data_q;
  logic              load_error_q;

  logic loading, byte_ok, mem_full, word_done, timeout;

  assign loading   = (state_q == LOAD_WAIT) || (state_q == LOAD_RX);
  // A press in the same cycle as a byte takes priority and drops that byte.
  assign byte_ok   = loading && rx_valid && !press;
  assign mem_full  = word_cnt_q[WC_W-1];
  assign word_done = byte_ok && !mem_full && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign timeout   = (state_q == LOAD_RX) && (idle_cnt_q == IDLE_W'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      RUN:       if (press) state_d = LOAD_WAIT;
      LOAD_WAIT: if (press) state_d = FINISH;
                 else if (rx_valid) state_d = LOAD_RX;
      LOAD_RX:   if (press || timeout) state_d = FINISH;
      FINISH:    state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      ld_imem_we_q <= 1'b0;
      ld_dmem_we_q <= 1'b0;
      ld_addr_q    <= '0;
      ld_data_q    <= '0;
      load_error_q <= 1'b0;
    end else begin
      ld_imem_we_q <= 1'b0;
      ld_dmem_we_q <= 1'b0;

      if (state_q == RUN && press) begin
        byte_cnt_q   <= '0;
        word_cnt_q   <= '0;
        idle_cnt_q   <= '0;
        load_error_q <= 1'b0;
      end

      if (state_q == LOAD_RX && (press || timeout))
        load_error_q <= (byte_cnt_q != '0);

      if (state_q == LOAD_RX && !byte_ok && !timeout)
        idle_cnt_q <= idle_cnt_q + 1'b1;

      if (byte_ok) begin
        idle_cnt_q <= '0;
        if (word_done) begin
          byte_cnt_q   <= '0;
          word_cnt_q   <= word_cnt_q + 1'b1;
          ld_addr_q    <= word_cnt_q[ADDR_W-1:0];
          ld_data_q    <= {rx_data, asm_q};
          ld_imem_we_q <= !word_cnt_q[ADDR_W];
          ld_dmem_we_q <= word_cnt_q[ADDR_W];
        end else if (!mem_full) begin
          asm_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end
    end
  end

  assign cpu_rst     = reset || (state_q != RUN);
  assign load_active = loading;
  assign load_error  = load_error_q;
  assign imem_we     = ld_imem_we_q;
  assign imem_addr   = ld_addr_q;
  assign imem_wdata  = ld_data_q;

  always_comb begin
    if (state_q == RUN) begin
      dmem_we    = cpu_dmem_we;
      dmem_addr  = cpu_dmem_addr;
      dmem_wdata = cpu_dmem_wdata;
    end else begin
      dmem_we    = ld_dmem_we_q;
      dmem_addr  = ld_addr_q;
      dmem_wdata = ld_data_q;
    end
  end

endmodule

// File: tb/tb_minisys_load_ctrl.sv
// Self-checking bench for minisys_load_ctrl: table-driven word stream with a
// write scoreboard, plus hand-written press/timeout/reset sequences.
module tb_minisys_load_ctrl;

  localparam int ADDR_W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              btn_mode;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              cpu_dmem_we;
  logic [ADDR_W-1:0] cpu_dmem_addr;
  logic [31:0]       cpu_dmem_wdata;
  logic              cpu_rst;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              load_active;
  logic              load_error;

  minisys_load_ctrl #(
    .DEB_CYCLES (4),
    .ADDR_W     (ADDR_W),
    .TIMEOUT    (20)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_mode       (btn_mode),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .cpu_dmem_we    (cpu_dmem_we),
    .cpu_dmem_addr  (cpu_dmem_addr),
    .cpu_dmem_wdata (cpu_dmem_wdata),
    .cpu_rst        (cpu_rst),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .load_active    (load_active),
    .load_error     (load_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic              dmem;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [31:0]       word;
    logic              exp_wr;
    logic              exp_dmem;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard: every loader write pulse must match the oldest pending word.
  always @(negedge clock) begin
    wr_t e;
    if (mon_en && (imem_we || dmem_we)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {30'd0, imem_we, dmem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_sel", {30'd0, imem_we, dmem_we}, {30'd0, !e.dmem, e.dmem});
        check("wr_addr", {30'd0, (e.dmem ? dmem_addr : imem_addr)}, {30'd0, e.addr});
        check("wr_data", e.dmem ? dmem_wdata : imem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic push, input logic dm,
                           input logic [ADDR_W-1:0] a);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && push) begin
        e.dmem = dm;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
      end
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic do_press();
    @(negedge clock);
    btn_mode = 1'b1;
    repeat (6) @(negedge clock);
    btn_mode = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (load_active && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("wait_idle_bound", {31'd0, load_active}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    vecs[0] = '{32'h12345678, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{32'hcafebabe, 1'b1, 1'b0, 2'd1};
    vecs[2] = '{32'h0badf00d, 1'b1, 1'b0, 2'd2};
    vecs[3] = '{32'hdeadbeef, 1'b1, 1'b0, 2'd3};
    vecs[4] = '{32'h01020304, 1'b1, 1'b1, 2'd0};
    vecs[5] = '{32'ha5a55a5a, 1'b1, 1'b1, 2'd1};
    vecs[6] = '{32'hffffffff, 1'b1, 1'b1, 2'd2};
    vecs[7] = '{32'h00000000, 1'b1, 1'b1, 2'd3};
    vecs[8] = '{32'h87654321, 1'b0, 1'b0, 2'd0};

    reset = 1'b1; btn_mode = 1'b0; rx_valid = 1'b0; rx_data = '0;
    cpu_dmem_we = 1'b0; cpu_dmem_addr = '0; cpu_dmem_wdata = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cpu_rst_high", {31'd0, cpu_rst}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_imem_addr", {30'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_load_active", {31'd0, load_active}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);

    // Short glitch must not be accepted
    @(negedge clock);
    btn_mode = 1'b1;
    repeat (2) @(negedge clock);
    btn_mode = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_no_load", {31'd0, load_active}, 32'd0);
    check("glitch_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Full load: imem 0..3, dmem 0..3, ninth word dropped
    do_press();
    check("press_load_active", {31'd0, load_active}, 32'd1);
    check("press_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    for (int i = 0; i < 9; i++)
      send_word(vecs[i].word, vecs[i].exp_wr, vecs[i].exp_dmem, vecs[i].exp_addr);
    wait_idle(n);
    check("full_load_error", {31'd0, load_error}, 32'd0);
    check("full_queue_empty", exp_q.size(), 32'd0);
    @(negedge clock);

    // Partial word followed by timeout
    do_press();
    send_word(32'h44332211, 1'b1, 1'b0, 2'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_idle(n);
    check("timeout_latency_ok", {31'd0, (n >= 20 && n <= 22)}, 32'd1);
    check("finish_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("timeout_load_error", {31'd0, load_error}, 32'd1);
    @(negedge clock);
    check("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("run_error_sticky", {31'd0, load_error}, 32'd1);
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_dmem_we    = (i != 1);
      cpu_dmem_addr  = ADDR_W'($urandom_range(0, 3));
      cpu_dmem_wdata = $urandom;
      #1;
      check("run_dmem_we", {31'd0, dmem_we}, {31'd0, (i != 1)});
      check("run_dmem_addr", {30'd0, dmem_addr}, {30'd0, cpu_dmem_addr});
      check("run_dmem_wdata", dmem_wdata, cpu_dmem_wdata);
      check("run_imem_we", {31'd0, imem_we}, 32'd0);
      @(negedge clock);
    end
    cpu_dmem_we = 1'b0;
    @(negedge clock);
    mon_en = 1'b1;

    // Press coincident with the 4th byte: byte dropped, no write
    do_press();
    send_byte(8'ha1);
    send_byte(8'ha2);
    send_byte(8'ha3);
    @(negedge clock);
    btn_mode = 1'b1;
    repeat (6) @(negedge clock);
    btn_mode = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'ha4;
    @(negedge clock);
    rx_valid = 1'b0;
    check("abort_load_active", {31'd0, load_active}, 32'd0);
    check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("abort_load_error", {31'd0, load_error}, 32'd1);
    @(negedge clock);
    check("abort_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("abort_no_write", exp_q.size(), 32'd0);

    // Reset mid-word, then the next load restarts at imem 0
    do_press();
    check("new_load_err_clear", {31'd0, load_error}, 32'd0);
    send_byte(8'hde);
    send_byte(8'had);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_load_active", {31'd0, load_active}, 32'd0);
    check("midrst_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
    check("midrst_imem_addr", {30'd0, imem_addr}, 32'd0);
    check("midrst_imem_wdata", imem_wdata, 32'd0);
    check("midrst_load_error", {31'd0, load_error}, 32'd0);
    do_press();
    send_word(32'hcafef00d, 1'b1, 1'b0, 2'd0);
    wait_idle(n);
    check("reload_load_error", {31'd0, load_error}, 32'd0);
    check("reload_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minisys_load_ctrl.md
# minisys_load_ctrl

Mode controller that shares the Minisys instruction and data memories between the MIPS CPU and the UART program loader. A debounced mode button toggles between RUN, where the CPU owns the memory write ports, and LOAD, where the CPU is held in reset and incoming UART bytes are packed into 32-bit words and written sequentially into instruction memory, then data memory. It sits in the top level between the board I/O (button, UART receiver), the CPU core and the two memory blocks.

## Interface
- DEB_CYCLES, 100000: consecutive stable-high cycles before a button press is accepted.
- ADDR_W, 14: word-address width of each memory.
- TIMEOUT, 5000000: idle cycles after the last byte that end a load.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- btn_mode  in  1  raw mode button, asynchronous.
- rx_valid  in  1  one-cycle strobe, new UART byte.
- rx_data  in  8  UART byte.
- cpu_dmem_we  in  1  CPU data-memory write enable.
- cpu_dmem_addr  in  ADDR_W  CPU data-memory word address.
- cpu_dmem_wdata  in  32  CPU store data.
- cpu_rst  out  1  reset to CPU core.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  loader instruction-memory address.
- imem_wdata  out  32  loader instruction word.
- dmem_we  out  1  data-memory write enable (muxed).
- dmem_addr  out  ADDR_W  data-memory address (muxed).
- dmem_wdata  out  32  data-memory write data (muxed).
- load_active  out  1  LED: loader owns memories.
- load_error  out  1  sticky: last load ended on a partial word.

## Operation
- Button path: 2-FF synchronizer, then a counter that reaches DEB_CYCLES only while the synchronized level is high; the debounced level rises when the count is reached and falls on the first low sample. One `press` pulse per debounced rising edge.
- States: RUN, LOAD_WAIT, LOAD_RX, FINISH.
- RUN: cpu_rst=0; dmem_* = cpu_dmem_* combinationally; imem_we=0. press -> LOAD_WAIT; clear word counter, byte counter, load_error.
- LOAD_WAIT: cpu_rst=1; waits for the first byte; no timeout. rx_valid -> LOAD_RX. press -> FINISH (abort).
- LOAD_RX: each byte is shifted into a little-endian assembler (first byte -> [7:0]). On the 4th byte the word is written: word index w < 2^ADDR_W -> imem at w; w < 2*2^ADDR_W -> dmem at w-2^ADDR_W. Bytes beyond 2*2^ADDR_W words are dropped. The idle counter is reset on each byte; when it reaches TIMEOUT -> FINISH, and load_error is set if the byte counter is nonzero.
- press in LOAD_RX -> FINISH immediately; the partial word is discarded, load_error=1 if partial. press wins over a same-cycle rx_valid, and that byte is dropped.
- FINISH: cpu_rst=1 for one cycle, then RUN.
- In every non-RUN state, CPU dmem writes are blocked and dmem_* carries loader values only.
- load_active=1 in LOAD_WAIT and LOAD_RX.

## Timing
- Reset values: state RUN, cpu_rst=1 while reset is high and 0 afterwards, imem_we=0, dmem_we=0 (loader side), addresses and data 0, load_active=0, load_error=0, all counters 0.
- Press latency: about DEB_CYCLES+2 cycles from the stable button level to `press`. The state changes on the cycle after `press`.
- Loader writes: 4th byte strobe at cycle t -> imem_we/dmem_we high for exactly one cycle at t+1, with addr/data registered.
- The RUN dmem path has zero latency.
- Reset mid-load discards all progress. Memory contents already written remain.

## Structure
- Shared package `minisys_pkg`: state encoding (RUN=0, LOAD_WAIT=1, LOAD_RX=2, FINISH=3) and the BYTES_PER_WORD=4 constant.
- One sub-module: `btn_debounce` (synchronizer, counter, press pulse), parameterized by DEB_CYCLES.
- The FSM, byte assembler, word counter, timeout counter and write mux live in the top module.

## Test plan
Bench parameters: DEB_CYCLES=4, TIMEOUT=20, ADDR_W=2.
- Reset, then hold btn_mode high for 6 cycles -> one press, load_active=1, cpu_rst=1. A 2-cycle glitch -> no state change.
- Bytes 78,56,34,12 -> imem_we pulse with addr 0, data 0x12345678. The next 4 bytes -> addr 1.
- 20 bytes -> imem addr 0..3 written, then dmem addr 0 on word 5. The 9th word's bytes -> no writes.
- 6 bytes then idle 20 cycles -> FINISH, load_error=1, cpu_rst one-cycle pulse, then RUN with dmem_* following cpu_dmem_*.
- Press on the same cycle as rx_valid in LOAD_RX -> the byte is dropped and the state goes FINISH -> RUN.
- Assert reset mid-word -> all outputs return to reset values and the next load starts at imem addr 0.
